fetch_queue: RTL and testbench

Instruction queue between the IF stage and the decode stage. Each cycle it captures the fetched `{instr, pc4}` pair, buffers up to DEPTH entries, and presents them in order to decode over a valid/ready handshake. It drives `pc_en` back to IF so the PC only advances when a slot is free. A redirect flush discards all buffered and in-flight fetches so that IF can load the branch or jump target.

---
 rtl/fetch_queue.sv | 59 +++++
 tb/tb_fetch_queue.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between IF and decode with redirect flush.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-low reset
//   if_instr/if_pc4 - fetched instruction and its PC+4 from IF
//   flush          - redirect; drops all buffered and in-flight fetches
//   pc_en          - tells IF to advance its PC; a fetch is taken when pc_en & ~flush
//   id_valid/id_instr/id_pc4/id_ready - valid/ready head-of-queue interface to decode
//   count          - current occupancy, 0..DEPTH
module fetch_queue #(
  parameter int DEPTH = 4,
  localparam int PTRW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc4,
  input  logic            flush,
  output logic            pc_en,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [31:0]     id_pc4,
  input  logic            id_ready,
  output logic [PTRW:0]   count
);
  localparam logic [PTRW:0] FULL = (PTRW+1)'(DEPTH);
  logic [63:0]     mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]   count_q, count_d;
  logic            push, pop;
  // pc_en looks only at registered occupancy and flush, so a pop never
  // frees a slot for a push in the same cycle and id_ready cannot reach IF.
  always_comb begin
    pc_en    = (count_q != FULL) | flush;
    id_valid = count_q != '0;
    push     = pc_en & ~flush;
    pop      = id_valid & id_ready & ~flush;
    id_instr = id_valid ? mem_q[rd_ptr_q][63:32] : '0;
    id_pc4   = id_valid ? mem_q[rd_ptr_q][31:0] : '0;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PTRW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PTRW'(pop);
    count_d  = flush ? '0 : count_q + (PTRW+1)'(push) - (PTRW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Storage is never cleared; output gating on id_valid hides stale entries.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= {if_instr, if_pc4};
  end
  assign count = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus randomized queue-model check of fetch_queue.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic        clk = 0, reset = 0, flush = 0, id_ready = 0;
  logic [31:0] if_instr = 0, if_pc4 = 0;
  logic        pc_en, id_valid;
  logic [31:0] id_instr, id_pc4;
  logic [2:0]  count;
  int n_chk = 0, n_fail = 0, pushes = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc4(if_pc4), .flush(flush),
    .pc_en(pc_en), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_ready(id_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          fl;
    bit          rdy;
    logic [31:0] pc4;
    bit          ev;
    logic [31:0] epc4;
    int          ecnt;
  } vec_t;

  vec_t vec [19];
  logic [63:0] q [$];
  logic [63:0] e;
  bit ps;

  function automatic logic [31:0] mk(logic [31:0] p);
    return {16'hC0DE, p[15:0]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 flush = 0;
    #1;
  endtask

  initial begin
    // Expected state after each row's edge (DEPTH=4); IF holds pc4 while pc_en=0.
    vec[0]  = '{1, 0, 1, 32'h3004, 1, 32'h3004, 1};
    vec[1]  = '{1, 0, 1, 32'h3008, 1, 32'h3008, 1};
    vec[2]  = '{1, 0, 1, 32'h300C, 1, 32'h300C, 1};
    vec[3]  = '{1, 0, 0, 32'h3010, 1, 32'h300C, 2};
    vec[4]  = '{1, 0, 0, 32'h3014, 1, 32'h300C, 3};
    vec[5]  = '{1, 0, 0, 32'h3018, 1, 32'h300C, 4};
    vec[6]  = '{1, 0, 0, 32'h301C, 1, 32'h300C, 4};
    vec[7]  = '{1, 0, 0, 32'h301C, 1, 32'h300C, 4};
    vec[8]  = '{1, 0, 0, 32'h301C, 1, 32'h300C, 4};
    vec[9]  = '{1, 0, 1, 32'h301C, 1, 32'h3010, 3};
    vec[10] = '{1, 0, 1, 32'h301C, 1, 32'h3014, 3};
    vec[11] = '{1, 0, 0, 32'h3020, 1, 32'h3014, 4};
    vec[12] = '{1, 0, 1, 32'h3024, 1, 32'h3018, 3};
    vec[13] = '{1, 1, 1, 32'h3028, 0, 32'h0,    0};
    vec[14] = '{1, 0, 1, 32'h3404, 1, 32'h3404, 1};
    vec[15] = '{1, 0, 0, 32'h3408, 1, 32'h3404, 2};
    vec[16] = '{0, 0, 1, 32'h340C, 0, 32'h0,    0};
    vec[17] = '{1, 0, 1, 32'h3500, 1, 32'h3500, 1};
    vec[18] = '{1, 0, 1, 32'h3504, 1, 32'h3504, 1};

    reset = 0;
    tick();
    tick();
    chk("reset valid", 32'(id_valid), 32'd0);
    chk("reset instr", id_instr, 32'd0);
    chk("reset pc4", id_pc4, 32'd0);
    chk("reset count", 32'(count), 32'd0);
    chk("reset pc_en", 32'(pc_en), 32'd1);

    for (int i = 0; i < 19; i++) begin
      reset    = vec[i].rst_n;
      flush    = vec[i].fl;
      id_ready = vec[i].rdy;
      if_pc4   = vec[i].pc4;
      if_instr = mk(vec[i].pc4);
      tick();
      chk($sformatf("row%0d valid", i), 32'(id_valid), 32'(vec[i].ev));
      chk($sformatf("row%0d pc4", i), id_pc4, vec[i].epc4);
      chk($sformatf("row%0d instr", i), id_instr, vec[i].ev ? mk(vec[i].epc4) : 32'd0);
      chk($sformatf("row%0d count", i), 32'(count), 32'(vec[i].ecnt));
      chk($sformatf("row%0d pc_en", i), 32'(pc_en), 32'(vec[i].ecnt != DEPTH));
    end

    // Flush must force pc_en high combinationally even when full.
    reset = 1; flush = 0; id_ready = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("full count", 32'(count), 32'd4);
    chk("full pc_en", 32'(pc_en), 32'd0);
    flush = 1;
    #1 chk("flush pc_en", 32'(pc_en), 32'd1);

    reset = 0;
    tick();
    q.delete();
    for (int c = 0; c < 600; c++) begin
      reset    = $urandom_range(99) != 0;
      flush    = $urandom_range(9) == 0;
      id_ready = 1'($urandom_range(1));
      if_instr = $urandom;
      if_pc4   = $urandom;
      #1 chk("rnd pre pc_en", 32'(pc_en), 32'((q.size() != DEPTH) || flush));
      if (!reset || flush) q.delete();
      else begin
        ps = q.size() != DEPTH;
        if (q.size() != 0 && id_ready) void'(q.pop_front());
        if (ps) begin
          q.push_back({if_instr, if_pc4});
          pushes++;
        end
      end
      tick();
      e = q.size() != 0 ? q[0] : 64'h0;
      chk("rnd valid", 32'(id_valid), 32'(q.size() != 0));
      chk("rnd instr", id_instr, e[63:32]);
      chk("rnd pc4", id_pc4, e[31:0]);
      chk("rnd count", 32'(count), 32'(q.size()));
      chk("rnd count bound", 32'(32'(count) <= DEPTH), 32'd1);
      chk("rnd pc_en", 32'(pc_en), 32'(q.size() != DEPTH));
    end
    chk("rnd wraps", 32'(pushes > 3 * DEPTH), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
